// File: rtl/inc_rr_arbiter.sv
// rtl/inc_rr_arbiter.sv - round-robin shared prefix incrementer with one-deep result register
module inc_prefix #(
  parameter int LOGWIDTH = 5
) (
  input  logic [(1<<LOGWIDTH)-1:0] a,
  output logic [(1<<LOGWIDTH)-1:0] s,
  output logic                     cout
);
  localparam int W = 1 << LOGWIDTH;

  // lvl[k][i] = AND of a[i] down to a[i-2**k+1]; final level gives the full prefix
  logic [LOGWIDTH:0][W-1:0] lvl;

  always_comb begin
    lvl    = '0;
    lvl[0] = a;
    for (int k = 0; k < LOGWIDTH; k++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << k))
          lvl[k+1][i] = lvl[k][i] & lvl[k][i-(1<<k)];
        else
          lvl[k+1][i] = lvl[k][i];
      end
    end
  end

  assign s    = a ^ {lvl[LOGWIDTH][W-2:0], 1'b1};
  assign cout = lvl[LOGWIDTH][W-1];
endmodule

module inc_rr_arbiter #(
  parameter int LOGWIDTH = 5,
  parameter int NREQ     = 4,
  parameter int IDW      = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ*(1<<LOGWIDTH)-1:0]    req_data,
  output logic [NREQ-1:0]                  req_ready,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [(1<<LOGWIDTH)-1:0]         resp_data,
  output logic                             resp_cout,
  output logic [IDW-1:0]                   resp_id,
  output logic [7:0]                       busy_cnt
);
  localparam int W = 1 << LOGWIDTH;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic            can_accept;
  logic            granted;
  logic [IDW-1:0]  gidx;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    inc_s;
  logic            inc_cout;

  // Gated by reset so nothing is offered while the block is held in reset
  assign can_accept = !reset && ((state == EMPTY) || resp_ready);

  always_comb begin
    req_ready = '0;
    granted   = 1'b0;
    gidx      = '0;
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = int'(ptr) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!granted && can_accept && req_valid[IDW'(idx)]) begin
        granted               = 1'b1;
        gidx                  = IDW'(idx);
        req_ready[IDW'(idx)]  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) sel_data = sel_data | req_data[i*W +: W];
  end

  inc_prefix #(.LOGWIDTH(LOGWIDTH)) u_inc (
    .a    (sel_data),
    .s    (inc_s),
    .cout (inc_cout)
  );

  assign resp_valid = (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      ptr       <= '0;
      resp_data <= '0;
      resp_cout <= 1'b0;
      resp_id   <= '0;
      busy_cnt  <= '0;
    end else begin
      if (granted) begin
        state     <= FULL;
        resp_data <= inc_s;
        resp_cout <= inc_cout;
        resp_id   <= gidx;
        ptr       <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end else if (state == FULL && resp_ready) begin
        state <= EMPTY;
      end
      if ((|req_valid) && !granted && busy_cnt != 8'hFF)
        busy_cnt <= busy_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_inc_rr_arbiter.sv
// tb/tb_inc_rr_arbiter.sv - directed bench with behavioural model for inc_rr_arbiter
module tb_inc_rr_arbiter;
  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req_valid = 4'b1111;
  logic [31:0]      op [4];
  logic [127:0]     req_data;
  logic [3:0]       req_ready;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [31:0]      resp_data;
  logic             resp_cout;
  logic [1:0]       resp_id;
  logic [7:0]       busy_cnt;

  int total = 0;
  int bad   = 0;

  assign req_data = {op[3], op[2], op[1], op[0]};

  inc_rr_arbiter #(.LOGWIDTH(5), .NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_cout  (resp_cout),
    .resp_id    (resp_id),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending result, rotation pointer, stall counter
  int          m_ptr  = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_cout = 1'b0;
  int          m_id   = 0;
  int          m_busy = 0;
  int          m_g;

  function automatic int model_pick(input int p, input logic [3:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always_comb begin
    m_g = -1;
    if (!reset && (!m_full || resp_ready)) m_g = model_pick(m_ptr, req_valid);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr  <= 0;
      m_full <= 1'b0;
      m_data <= '0;
      m_cout <= 1'b0;
      m_id   <= 0;
      m_busy <= 0;
    end else begin
      if (m_g >= 0) begin
        {m_cout, m_data} <= {1'b0, op[m_g]} + 33'd1;
        m_id   <= m_g;
        m_full <= 1'b1;
        m_ptr  <= (m_g + 1) % NREQ;
      end else if (resp_ready) begin
        m_full <= 1'b0;
      end
      if (req_valid != 0 && m_g < 0 && m_busy < 255) m_busy <= m_busy + 1;
    end
  end

  always @(negedge clk) begin
    check("req_ready", 64'(req_ready), (m_g >= 0) ? 64'(4'b1 << m_g) : 64'd0);
    check("resp_valid", 64'(resp_valid), 64'(m_full));
    if (m_full) begin
      check("resp_data", 64'(resp_data), 64'(m_data));
      check("resp_cout", 64'(resp_cout), 64'(m_cout));
      check("resp_id", 64'(resp_id), 64'(m_id));
    end
    check("busy_cnt", 64'(busy_cnt), 64'(m_busy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int b0;

  initial begin
    op[0] = 32'h10; op[1] = 32'h20; op[2] = 32'h30; op[3] = 32'h40;
    repeat (3) step();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy_cnt), 64'd0);
    reset = 1'b0;
    #1;
    check("first_grant", 64'(req_ready), 64'h1);

    // Fairness: all valid, ready high, expect 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_valid", 64'(resp_valid), 64'd1);
      check("rr_id", 64'(resp_id), 64'(k % 4));
    end

    // Single requester 2
    req_valid = 4'b0100; op[2] = 32'h0000_00FF;
    step();
    req_valid = 4'b0000;
    check("single_data", 64'(resp_data), 64'h100);
    check("single_cout", 64'(resp_cout), 64'd0);
    check("single_id", 64'(resp_id), 64'd2);

    // Wrap and carry
    req_valid = 4'b0001; op[0] = 32'hFFFF_FFFF;
    step();
    check("wrap_data", 64'(resp_data), 64'h0);
    check("wrap_cout", 64'(resp_cout), 64'd1);
    op[0] = 32'h7FFF_FFFF;
    step();
    req_valid = 4'b0000;
    check("msb_data", 64'(resp_data), 64'h8000_0000);
    check("msb_cout", 64'(resp_cout), 64'd0);
    step();

    // Backpressure with requesters 1 and 3; pointer is 1 after last grant to 0
    op[1] = 32'h1111; op[3] = 32'h3333;
    req_valid = 4'b1010;
    step();
    check("bp_first_id", 64'(resp_id), 64'd1);
    resp_ready = 1'b0;
    b0 = int'(busy_cnt);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_id", 64'(resp_id), 64'd1);
      check("bp_data", 64'(resp_data), 64'h1112);
    end
    check("bp_busy_delta", 64'(int'(busy_cnt) - b0), 64'd5);
    resp_ready = 1'b1;
    step();
    check("bp_refill_valid", 64'(resp_valid), 64'd1);
    check("bp_refill_id", 64'(resp_id), 64'd3);
    check("bp_refill_data", 64'(resp_data), 64'h3334);
    step();
    check("pre_rst_id", 64'(resp_id), 64'd1);

    // Mid-stream reset while stalled with pointer at 2
    resp_ready = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'b0010);
    resp_ready = 1'b1;
    step();
    check("post_rst_id", 64'(resp_id), 64'd1);
    req_valid = 4'b0000;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inc_rr_arbiter.md
Name: inc_rr_arbiter

Overview:
- Shares one combinational prefix incrementer (inc_prefix, LOGWIDTH-parameterised) between NREQ requesters, e.g. the PC sequencer, the loop/index counter and debug counters of the MIPS core.
- Requesters present operands with a valid/ready handshake. A round-robin arbiter picks one per cycle and the incremented result lands in a one-deep output register. The result carries the winner's ID back through a valid/ready response channel.

Parameters:
- LOGWIDTH, 5, log2 of operand width (W = 2**LOGWIDTH = 32).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID, equal to clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_data  input  NREQ*W  packed operands; requester i occupies bits [i*W +: W].
- req_ready  output  NREQ  one-hot grant; operand i is accepted when req_valid[i] & req_ready[i].
- resp_valid  output  1  result register holds valid data.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  W  operand + 1, mod 2**W.
- resp_cout  output  1  carry out (operand was all ones).
- resp_id  output  IDW  index of the requester that produced the result.
- busy_cnt  output  8  saturating count of cycles in which at least one valid request was not granted.

Behaviour:
Reset:
- Asynchronous, active-high.
- Clears resp_valid, resp_data, resp_cout, resp_id and busy_cnt to 0.
- Sets the round-robin pointer to 0, so requester 0 has the highest priority.
- Output FSM goes to EMPTY.

Output FSM:
- Two states, EMPTY and FULL; resp_valid = (state == FULL).
- can_accept = EMPTY | (FULL & resp_ready). A full register drains and refills in the same cycle with no bubble.
- EMPTY -> FULL when a grant occurs.
- FULL -> EMPTY when resp_ready is high and there is no grant.
- FULL stays FULL when resp_ready is high with a grant (new data loaded), or when resp_ready is low (data held).

Arbitration:
- Combinational. req_ready is all-zero unless can_accept.
- Otherwise exactly one bit is set: the first i with req_valid[i], scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
- req_ready may depend on req_valid (no combinational path from req_data). Requesters must not make req_valid depend on req_ready.
- On a grant to g, ptr <= (g+1) mod NREQ. With no grant, ptr is unchanged.

Datapath:
- The winner's operand is muxed into one inc_prefix instance.
- On a grant, register resp_data <= S, resp_cout <= Cout, resp_id <= g.
- Latency: accept in cycle N gives resp_valid high in cycle N+1.
- Throughput: 1 per cycle when resp_ready is held high.
- All-ones operand gives resp_data = 0 and resp_cout = 1.

Stall:
- While FULL & !resp_ready, the response outputs are stable and all req_ready bits are 0.
- Requesters must hold req_valid and req_data until accepted.

busy_cnt:
- Increments each cycle in which (|req_valid) & !(|(req_valid & req_ready)).
- Saturates at 255.

Boundary conditions:
- Simultaneous requests are served strictly in rotation. No requester waits more than NREQ-1 grants while continuously valid.
- Reset asserted mid-transaction discards the held result and the pointer immediately. No response is produced for an operand accepted in the reset cycle.
- NREQ not a power of two: IDs NREQ..2**IDW-1 never appear. Pointer wrap uses mod NREQ, not a bit-width wrap.

Test Plan:
- Reset check: assert reset with req_valid = 4'b1111 -> req_ready = 0, resp_valid = 0, busy_cnt = 0. First cycle after release grants requester 0.
- Single requester: requester 2 sends 0x0000_00FF with resp_ready = 1 -> next cycle resp_valid = 1, resp_data = 0x0000_0100, resp_cout = 0, resp_id = 2.
- Wrap and carry: operand 0xFFFF_FFFF -> resp_data = 0x0000_0000, resp_cout = 1. Operand 0x7FFF_FFFF -> 0x8000_0000, resp_cout = 0.
- Round-robin fairness: all four requesters continuously valid, resp_ready = 1 -> resp_id sequence 0,1,2,3,0,1,... with one result per cycle and no bubbles.
- Backpressure: hold resp_ready = 0 for 5 cycles while requesters 1 and 3 are valid -> result stable, req_ready = 0, busy_cnt += 5. Releasing resp_ready drains and loads the next grant in the same cycle.
- Mid-stream reset: reset pulsed while FULL with resp_ready = 0 -> resp_valid drops asynchronously and ptr returns to 0. After release, simultaneous requests from 1 and 3 grant requester 1 first.
